// File: rtl/sram_port0_ctrl.sv
// Valid/ready adapter for port 0 (RW) of the 32x256 1RW1R SRAM macro.
// Optional macro SRAM_PERF_CNT_EN adds issued read/write counters.
module sram_port0_ctrl #(
  parameter int BUS_AW     = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [BUS_AW-1:0]     req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_WMASKS-1:0] req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [NUM_WMASKS-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i
`ifdef SRAM_PERF_CNT_EN
  ,
  input  logic                  cnt_clr_i,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
`endif
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic                  pend_valid;
  logic                  pend_read;
  logic                  pend_err;
  logic [CW-1:0]         count;
  logic [CW:0]           used;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] rdata_q [RSP_DEPTH];
  logic                  err_q   [RSP_DEPTH];
  logic                  addr_err;
  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  full;

  assign addr_err = (|req_addr_i[1:0])
                  | (|req_addr_i[BUS_AW-1:ADDR_WIDTH+2]);

  // Credit counts the in-flight pend entry, so a push never finds the FIFO full
  assign used        = {1'b0, count} + {{CW{1'b0}}, pend_valid};
  assign req_ready_o = rst_ni & (used < (CW+1)'(RSP_DEPTH));

  assign accept = req_valid_i & req_ready_o;
  assign issue  = accept & ~addr_err;
  assign push   = pend_valid;
  assign full   = (count == CW'(RSP_DEPTH));

  assign rsp_valid_o = (count != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q[rd_ptr] : '0;
  assign rsp_err_o   = rsp_valid_o & err_q[rd_ptr];

  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (rst_ni) begin
      sram_csb_o  = ~issue;
      sram_web_o  = ~req_we_i;
      sram_addr_o = req_addr_i[ADDR_WIDTH+1:2];
      sram_din_o  = req_wdata_i;
      if (req_we_i) begin
        sram_wmask_o = req_be_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_valid <= 1'b0;
      pend_read  <= 1'b0;
      pend_err   <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      pend_valid <= accept;
      if (accept) begin
        pend_read <= ~req_we_i;
        pend_err  <= addr_err;
      end
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(RSP_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(RSP_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rdata_q[wr_ptr] <= (pend_read & ~pend_err) ? sram_dout_i : '0;
      err_q[wr_ptr]   <= pend_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push && !pop) begin
      assert (!full);
    end
  end

`ifdef SRAM_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni || cnt_clr_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (issue && !req_we_i && rd_cnt_o != '1) begin
        rd_cnt_o <= rd_cnt_o + 1'b1;
      end
      if (issue && req_we_i && wr_cnt_o != '1) begin
        wr_cnt_o <= wr_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Directed bench for sram_port0_ctrl with a behavioural port-0 macro model.
// Build with SRAM_PERF_CNT_EN to also exercise the counters.
module tb_sram_port0_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sram_csb;
  logic        sram_web;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
`ifdef SRAM_PERF_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  sram_port0_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .sram_csb_o  (sram_csb),
    .sram_web_o  (sram_web),
    .sram_wmask_o(sram_wmask),
    .sram_addr_o (sram_addr),
    .sram_din_o  (sram_din),
    .sram_dout_i (sram_dout)
`ifdef SRAM_PERF_CNT_EN
    ,
    .cnt_clr_i   (cnt_clr),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt)
`endif
  );

  // Port-0 macro: masked write or 1-cycle registered read on csb low
  always @(posedge clk) begin
    logic [31:0] w;
    if (!sram_csb) begin
      if (!sram_web) begin
        w = mem[sram_addr];
        for (int b = 0; b < 4; b++) begin
          if (sram_wmask[b]) w[8*b +: 8] = sram_din[8*b +: 8];
        end
        mem[sram_addr] = w;
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    #1;
  endtask

  task automatic idle;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic acc(input string tag, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be);
    drive(we, addr, wd, be);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    tick;
    idle;
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] rd,
                         input logic err);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(rd));
    chk({tag, "_err"}, 64'(rsp_err), 64'(err));
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_ni    = 1'b0;
    rsp_ready = 1'b0;
    req_be    = 4'hF;
    req_wdata = 32'h5555_5555;
    drive(1'b1, 32'h10, 32'h5555_5555, 4'hF);
    tick;
    tick;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_csb", 64'(sram_csb), 64'd1);
    chk("rst_web", 64'(sram_web), 64'd1);
    chk("rst_wmask", 64'(sram_wmask), 64'd0);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_din", 64'(sram_din), 64'd0);
    chk("rst_rvalid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rerr", 64'(rsp_err), 64'd0);
    idle;
    rst_ni = 1'b1;
    tick;

    // write then read 0x10, exact response timing
    rsp_ready = 1'b1;
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    chk("w_ready", 64'(req_ready), 64'd1);
    chk("w_csb", 64'(sram_csb), 64'd0);
    chk("w_web", 64'(sram_web), 64'd0);
    chk("w_addr", 64'(sram_addr), 64'h04);
    chk("w_wmask", 64'(sram_wmask), 64'hF);
    chk("w_din", 64'(sram_din), 64'hDEAD_BEEF);
    tick;
    drive(1'b0, 32'h10, 32'h0, 4'hF);
    chk("r_early", 64'(rsp_valid), 64'd0);
    chk("r_csb", 64'(sram_csb), 64'd0);
    chk("r_web", 64'(sram_web), 64'd1);
    chk("r_wmask", 64'(sram_wmask), 64'd0);
    chk("r_addr", 64'(sram_addr), 64'h04);
    tick;
    idle;
    chk("wrsp_valid", 64'(rsp_valid), 64'd1);
    chk("wrsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("wrsp_err", 64'(rsp_err), 64'd0);
    tick;
    chk("rrsp_valid", 64'(rsp_valid), 64'd1);
    chk("rrsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    chk("rrsp_err", 64'(rsp_err), 64'd0);
    tick;
    chk("rrsp_gone", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b0;

    // byte-masked write
    acc("mw0", 1'b1, 32'h20, 32'hAAAA_AAAA, 4'hF);
    acc("mw1", 1'b1, 32'h20, 32'h1122_3344, 4'b0101);
    acc("mr", 1'b0, 32'h20, 32'h0, 4'hF);
    get_rsp("mw0_rsp", 32'h0, 1'b0);
    get_rsp("mw1_rsp", 32'h0, 1'b0);
    get_rsp("mr_rsp", 32'hAA22_AA44, 1'b0);

    // misaligned and out-of-range reads
    drive(1'b0, 32'h402, 32'h0, 4'hF);
    chk("mis_csb", 64'(sram_csb), 64'd1);
    tick;
    drive(1'b0, 32'h400, 32'h0, 4'hF);
    chk("oor_csb", 64'(sram_csb), 64'd1);
    tick;
    idle;
    get_rsp("mis_rsp", 32'h0, 1'b1);
    get_rsp("oor_rsp", 32'h0, 1'b1);

    // preload 8 words back to back
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 32'h80 + 32'(4*c), 32'hC0DE_0000 + 32'(c), 4'hF);
      chk("pre_ready", 64'(req_ready), 64'd1);
      tick;
    end
    idle;
    tick;
    tick;
    tick;
    chk("pre_drained", 64'(rsp_valid), 64'd0);

    // streaming reads, one response per cycle
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drive(1'b0, 32'h80 + 32'(4*c), 32'h0, 4'hF);
      else idle;
      #1;
      if (c < 8) chk("st_ready", 64'(req_ready), 64'd1);
      tick;
      if (c >= 1 && c <= 8) begin
        chk("st_valid", 64'(rsp_valid), 64'd1);
        chk("st_rdata", 64'(rsp_rdata), 64'(32'hC0DE_0000 + 32'(c - 1)));
      end else begin
        chk("st_idle", 64'(rsp_valid), 64'd0);
      end
    end
    idle;
    rsp_ready = 1'b0;

    // backpressure: only three reads fit
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h80 + 32'(4*c), 32'h0, 4'hF);
      chk("bp_ready", 64'(req_ready), 64'd1);
      tick;
    end
    drive(1'b0, 32'h8C, 32'h0, 4'hF);
    chk("bp_full0", 64'(req_ready), 64'd0);
    tick;
    chk("bp_full1", 64'(req_ready), 64'd0);
    chk("bp_csb", 64'(sram_csb), 64'd1);
    idle;
    get_rsp("bp0", 32'hC0DE_0000, 1'b0);
    get_rsp("bp1", 32'hC0DE_0001, 1'b0);
    get_rsp("bp2", 32'hC0DE_0002, 1'b0);
    chk("bp_only3", 64'(rsp_valid), 64'd0);
    acc("bp3", 1'b0, 32'h8C, 32'h0, 4'hF);
    acc("bp4", 1'b0, 32'h90, 32'h0, 4'hF);
    get_rsp("bp3_rsp", 32'hC0DE_0003, 1'b0);
    get_rsp("bp4_rsp", 32'hC0DE_0004, 1'b0);

    // reset with two responses queued
    acc("rq0", 1'b0, 32'h94, 32'h0, 4'hF);
    acc("rq1", 1'b0, 32'h98, 32'h0, 4'hF);
    tick;
    tick;
    chk("rq_queued", 64'(rsp_valid), 64'd1);
    rst_ni = 1'b0;
    tick;
    rst_ni = 1'b1;
    chk("rq_flushed", 64'(rsp_valid), 64'd0);
`ifdef SRAM_PERF_CNT_EN
    chk("rq_rdcnt", 64'(rd_cnt), 64'd0);
    chk("rq_wrcnt", 64'(wr_cnt), 64'd0);
`endif
    rsp_ready = 1'b1;
    tick;
    tick;
    tick;
    chk("rq_nostale", 64'(rsp_valid), 64'd0);
    chk("rq_ready", 64'(req_ready), 64'd1);

`ifdef SRAM_PERF_CNT_EN
    acc("pc_w", 1'b1, 32'h40, 32'h1, 4'hF);
    acc("pc_r", 1'b0, 32'h40, 32'h0, 4'hF);
    acc("pc_e", 1'b0, 32'h41, 32'h0, 4'hF);
    chk("pc_rd", 64'(rd_cnt), 64'd1);
    chk("pc_wr", 64'(wr_cnt), 64'd1);
    cnt_clr = 1'b1;
    acc("pc_clr", 1'b0, 32'h40, 32'h0, 4'hF);
    cnt_clr = 1'b0;
    chk("pc_clr_rd", 64'(rd_cnt), 64'd0);
    chk("pc_clr_wr", 64'(wr_cnt), 64'd0);
    tick;
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port0_ctrl.md
Name: sram_port0_ctrl

Overview:
- Valid/ready request-response adapter that drives the RW port (port 0) of the 32x256 1RW1R SRAM macro.
- Upstream: the bus-side device adapter. Downstream: the macro pins csb0/web0/wmask0/addr0/din0/dout0.
- Converts byte addresses to word indices and rejects bad accesses before they reach the array.
- Returns responses in order through a small response FIFO, so rsp_ready backpressure never stalls the macro mid-access.

Parameters:
- BUS_AW, 32, request byte-address width
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 8, SRAM word-address width (depth = 2^ADDR_WIDTH)
- NUM_WMASKS, 4, byte lanes (DATA_WIDTH/8)
- RSP_DEPTH, 3, response FIFO entries; must be >= 2

Ports:
- clk_i  in  1  clock; also drives the macro's clk0
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  BUS_AW  byte address
- req_wdata_i  in  DATA_WIDTH  write data
- req_be_i  in  NUM_WMASKS  byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err_o  out  1  access error
- sram_csb_o  out  1  macro csb0 (active low)
- sram_web_o  out  1  macro web0 (active low)
- sram_wmask_o  out  NUM_WMASKS  macro wmask0
- sram_addr_o  out  ADDR_WIDTH  macro addr0
- sram_din_o  out  DATA_WIDTH  macro din0
- sram_dout_i  in  DATA_WIDTH  macro dout0

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low, sampled on the rising clk_i edge.
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_din_o=0.
  - While rst_ni=0, req_ready_o is forced 0 combinationally, so no macro access occurs during reset.
- Acceptance and credit:
  - A request is accepted on an edge where req_valid_i & req_ready_o.
  - req_ready_o = rst_ni & (fifo_count + pend_valid < RSP_DEPTH).
  - req_ready_o uses registered state only; there is no rsp_ready_i -> req_ready_o path.
- Error check, per request:
  - err = (req_addr_i[1:0] != 0) | (req_addr_i[BUS_AW-1:ADDR_WIDTH+2] != 0).
- Issue path (combinational from the accepted request):
  - sram_csb_o = ~(req_valid_i & req_ready_o & ~err)
  - sram_web_o = ~req_we_i
  - sram_wmask_o = req_we_i ? req_be_i : 0
  - sram_addr_o = req_addr_i[ADDR_WIDTH+1:2]
  - sram_din_o = req_wdata_i
  - Errored requests never assert csb but still produce a response.
- Pending stage: on acceptance, register {is_read, err} into a pend entry (pend_valid=1).
- Response capture, on the edge after acceptance:
  - Push the pend entry into the FIFO with rdata = (is_read & ~err) ? sram_dout_i : 0.
  - Read latency is 1 cycle to capture, so rsp_valid_o is first seen the cycle after capture: 2 edges after acceptance.
- FIFO:
  - rsp_valid_o = FIFO non-empty; rsp_rdata_o/rsp_err_o come from the registered head entry.
  - Pop on rsp_valid_o & rsp_ready_i. Same-edge push and pop are allowed, and count is unchanged.
  - Overflow is impossible by credit; pushing to a full FIFO is a design error (assertion).
- Throughput: with RSP_DEPTH>=3 and rsp_ready_i held at 1, one request is accepted per cycle. With RSP_DEPTH=2, the maximum rate is 2 accepts per 3 cycles.
- Write with be=0: csb and web asserted, no bytes change, response err=0.
- Ordering: responses return in strict acceptance order.
- Reset mid-operation: the pend entry and FIFO contents are discarded and no responses are issued for them. A write accepted on the reset edge is not issued.

Optional Feature:
- Macro: SRAM_PERF_CNT_EN.
- Defined:
  - Adds outputs rd_cnt_o [31:0] and wr_cnt_o [31:0].
  - Each increments by 1 per non-errored read/write actually issued to the macro (csb=0).
  - Both saturate at 0xFFFFFFFF and reset to 0.
  - Adds input cnt_clr_i [0:0], which zeroes both counters on the next edge and takes priority over increment on the same edge.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write addr 0x10, wdata 0xDEADBEEF, be 0xF; then read 0x10 -> write response err=0 rdata=0; read response rdata=0xDEADBEEF 2 edges after acceptance; sram_addr_o=0x04 at issue.
- Byte-masked write 0x11223344, be=0b0101, to a word holding 0xAAAAAAAA -> readback 0xAA22AA44.
- Read 0x402 (misaligned) and 0x400 (out of range, ADDR_WIDTH=8) -> sram_csb_o stays 1 both cycles; responses err=1, rdata=0.
- rsp_ready_i=0, 5 back-to-back reads -> exactly 3 accepted, then req_ready_o=0. Release rsp_ready_i -> 3 responses in order, then the remaining 2 accepted and returned.
- Continuous reads of 8 addresses with rsp_ready_i=1 -> req_ready_o stays 1 and 8 in-order responses arrive on consecutive cycles.
- rst_ni low for 1 edge with 2 responses queued -> rsp_valid_o=0 next cycle, no stale responses afterwards. With SRAM_PERF_CNT_EN, rd_cnt_o=0.
